// File: rtl/mips_mc_pkg.sv
// ============================================================================
// Module   : mips_mc_pkg
// Purpose  : Shared encodings for the multicycle MIPS controller. This covers
//            the FSM state enum, the opcode and funct fields, the aluop codes
//            and the alucontrol codes.
// Config   : ADDI_J_EN adds the ADDIEX, ADDIWB and JUMP states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mc_pkg;

  // FSM states. The encodings are fixed because state_o exposes them for debug.
`ifdef ADDI_J_EN
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8
  } state_t;
`endif

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // aluop encodings, which the FSM passes to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alucontrol encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mips_aludec.sv
// ============================================================================
// Module   : mips_aludec
// Purpose  : ALU decoder. It maps the FSM aluop and the R-type funct field to
//            the 3-bit ALU operation.
// Config   : not affected by ADDI_J_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_aludec
  import mips_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed add/subtract for address and branch work; funct only matters for R-type
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_controller.sv
// ============================================================================
// Module   : mips_mc_controller
// Purpose  : Moore FSM controller for a multicycle MIPS datapath. It also
//            counts retired instructions.
// Config   : defining ADDI_J_EN adds support for addi and j. When it is not
//            defined, those opcodes are treated as undefined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_controller
  import mips_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcen,
  output logic        irwrite,
  output logic        regwrite,
  output logic        memwrite,
  output logic        alusrca,
  output logic        iord,
  output logic        memtoreg,
  output logic        regdst,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic [3:0]  state_o,
  output logic [15:0] instret
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instret;

  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic       w_retire;
  logic [1:0] w_aluop;

  // State register. Reset asynchronously aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and Moore outputs. w_retire marks the last state of a real instruction.
  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_retire   = 1'b0;
    w_aluop    = ALUOP_ADD;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
`ifdef ADDI_J_EN
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
`ifdef ADDI_J_EN
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Retired-instruction counter. It wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_instret <= 16'd0;
    else if (w_retire) r_instret <= r_instret + 16'd1;
  end

  // The write strobes are gated by reset so that they drop the instant reset asserts.
  // Because branch is only set in BRANCH, zero can only affect pcen there.
  assign pcen     = reset & (w_pcwrite | (w_branch & zero));
  assign irwrite  = reset & w_irwrite;
  assign regwrite = reset & w_regwrite;
  assign memwrite = reset & w_memwrite;
  assign state_o  = r_state;
  assign instret  = r_instret;

  mips_aludec u_aludec (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
// ============================================================================
// Module   : tb_mips_mc_controller
// Purpose  : Scoreboard bench for mips_mc_controller. The instruction-level
//            reference model pushes expected per-cycle outputs into a queue,
//            and a monitor pops and compares one entry per cycle.
// Config   : follows ADDI_J_EN when deciding whether addi/j are defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mips_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        pcen, irwrite, regwrite, memwrite;
  logic        alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [3:0]  state_o;
  logic [15:0] instret;

`ifdef ADDI_J_EN
  localparam bit ADDI_J = 1'b1;
`else
  localparam bit ADDI_J = 1'b0;
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct packed {
    logic [3:0]  st;
    logic        pcen, irwrite, regwrite, memwrite;
    logic        alusrca, iord, memtoreg, regdst;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  aluctl;
    logic [15:0] instret;
  } step_t;

  step_t       expq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] model_cnt = 16'd0;

  mips_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .state_o    (state_o),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Default cycle record: no strobes, and the ALU adds
  function automatic step_t blank(input logic [3:0] st);
    step_t s;
    s         = '0;
    s.st      = st;
    s.aluctl  = 3'b010;
    s.instret = model_cnt;
    return s;
  endfunction

  // Operation the ALU performs for an R-type instruction
  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Reference model. Call it at a FETCH cycle; it queues every cycle of the
  // instruction, then waits until the next FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    step_t s;
    int    n;
    bit    ret;
    op = o; funct = f; zero = z;
    s = blank(4'd0); s.pcen = 1'b1; s.irwrite = 1'b1; s.alusrcb = 2'b01; expq.push_back(s);
    s = blank(4'd1); s.alusrcb = 2'b11; expq.push_back(s);
    n = 2; ret = 1'b1;
    if (o == LW) begin
      s = blank(4'd2); s.alusrca = 1'b1; s.alusrcb = 2'b10; expq.push_back(s);
      s = blank(4'd3); s.iord = 1'b1; expq.push_back(s);
      s = blank(4'd4); s.memtoreg = 1'b1; s.regwrite = 1'b1; expq.push_back(s);
      n = 5;
    end else if (o == SW) begin
      s = blank(4'd2); s.alusrca = 1'b1; s.alusrcb = 2'b10; expq.push_back(s);
      s = blank(4'd5); s.iord = 1'b1; s.memwrite = 1'b1; expq.push_back(s);
      n = 4;
    end else if (o == RT) begin
      s = blank(4'd6); s.alusrca = 1'b1; s.aluctl = rtype_alu(f); expq.push_back(s);
      s = blank(4'd7); s.regdst = 1'b1; s.regwrite = 1'b1; expq.push_back(s);
      n = 4;
    end else if (o == BEQ) begin
      s = blank(4'd8); s.alusrca = 1'b1; s.aluctl = 3'b110; s.pcsrc = 2'b01; s.pcen = z;
      expq.push_back(s);
      n = 3;
    end else if (ADDI_J && o == ADDI) begin
      s = blank(4'd9); s.alusrca = 1'b1; s.alusrcb = 2'b10; expq.push_back(s);
      s = blank(4'd10); s.regwrite = 1'b1; expq.push_back(s);
      n = 4;
    end else if (ADDI_J && o == JMP) begin
      s = blank(4'd11); s.pcsrc = 2'b10; s.pcen = 1'b1; expq.push_back(s);
      n = 3;
    end else begin
      ret = 1'b0;
    end
    repeat (n) @(posedge clk);
    if (ret) model_cnt = model_cnt + 16'd1;
    #1;
  endtask

  // Monitor: one expected record per cycle while the queue holds entries
  always @(negedge clk) begin
    step_t e;
    step_t a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a = {state_o, pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol, instret};
      check($sformatf("step_state%0d", e.st), 64'(a), 64'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rop;
    logic [5:0] rf;
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b0; op = LW; funct = 6'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {60'd0, state_o}, 64'd0);
    check("reset_instret", {48'd0, instret}, 64'd0);
    check("reset_strobes", {60'd0, pcen, irwrite, regwrite, memwrite}, 64'd0);

    // The FETCH cycle follows reset release, while lw is held on op
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr(LW, 6'd0, 1'b0);
    check("instret_after_lw", {48'd0, instret}, 64'd1);

    run_instr(RT, 6'b101010, 1'b0);
    run_instr(BEQ, 6'd0, 1'b1);
    run_instr(BEQ, 6'd0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b1);
    run_instr(ADDI, 6'd0, 1'b1);
    run_instr(JMP, 6'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = (($urandom_range(0, 3)) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      rf  = (($urandom_range(0, 2)) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(rop, rf, 1'($urandom));
    end

    // Reset arrives while a sw is in MEMWR
    op = SW; zero = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("memwr_reached", {59'd0, state_o, memwrite}, {59'd0, 4'd5, 1'b1});
    reset = 1'b0; #1;
    check("abort_strobes", {56'd0, state_o, pcen, irwrite, regwrite, memwrite}, 64'd0);
    @(posedge clk); #1;
    check("abort_instret", {48'd0, instret}, 64'd0);
    model_cnt = 16'd0;
    reset = 1'b1;

    // Preload the counter so that it sits at its wrap point
    dut.r_instret = 16'hFFFF;
    model_cnt = 16'hFFFF;
    run_instr(SW, 6'd0, 1'b1);
    check("instret_wrap", {48'd0, instret}, 64'd0);
    run_instr(ADDI, 6'd0, 1'b0);
    run_instr(LW, 6'd0, 1'b1);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 Parameters: none; all encodings are fixed constants in the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction opcode from the datapath instruction register.
REQ-005 funct  input  6  R-type function field.
REQ-006 zero  input  1  ALU zero flag from the datapath.
REQ-007 pcen  output  1  PC register enable, equal to pcwrite OR (branch AND zero).
REQ-008 irwrite, regwrite, memwrite  output  1 each  instruction register, register file and memory write strobes.
REQ-009 alusrca, iord, memtoreg, regdst  output  1 each  datapath mux selects.
REQ-010 alusrcb, pcsrc  output  2 each  ALU source B select and PC source select.
REQ-011 alucontrol  output  3  ALU operation.
REQ-012 state_o  output  4  current FSM state, for debug.
REQ-013 instret  output  16  count of retired instructions.

Function
REQ-014 The block SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-015 The FSM SHALL take these transitions:
- FETCH->DECODE.
- DECODE: lw(100011) or sw(101011)->MEMADR; R-type(000000)->EXECUTE; beq(000100)->BRANCH; addi(001000)->ADDIEX; j(000010)->JUMP; any other op->FETCH.
- MEMADR: lw->MEMRD, sw->MEMWR.
- MEMRD->MEMWB.
- EXECUTE->ALUWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
- Unused encodings 12-15->FETCH.
REQ-016 Outputs per state (all others 0; aluop 00 = add):
- FETCH: alusrcb=01, irwrite=1, pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-017 ALU decode:
- aluop 00->010; aluop 01->110.
- aluop 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other funct->010.
REQ-018 Latency SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; undefined op 2 cycles (no writes).
REQ-019 instret SHALL increment by 1 on each clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP, and SHALL wrap from 16'hFFFF to 0; undefined ops SHALL NOT count.
REQ-020 zero SHALL affect pcen only in BRANCH.

Reset
REQ-021 While reset=0, the state SHALL be FETCH, instret SHALL be 0, and pcen, irwrite, regwrite and memwrite SHALL be forced to 0 combinationally.
REQ-022 Reset asserted mid-instruction SHALL abort that instruction, with no further write strobes and no instret increment.
REQ-023 The first rising edge after reset=1 SHALL execute FETCH.

Configuration
REQ-024 With ADDI_J_EN defined, addi and j SHALL be supported per REQ-015.
REQ-025 Without ADDI_J_EN, the ADDIEX, ADDIWB and JUMP states SHALL not exist, addi and j opcodes SHALL go DECODE->FETCH, and encodings 9-15 SHALL go to FETCH.

Structure
REQ-026 Package mips_mc_pkg SHALL hold the state enum, opcode and funct constants, the aluop encodings and the alucontrol encodings.
REQ-027 ALU decode SHALL be the sub-module mips_aludec (aluop, funct -> alucontrol); the FSM and the counter live in the top.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Reset released with op=lw held: states 0,1,2,3,4,0; regwrite=1 only in state 4; instret=1.
- R-type with funct=101010: alucontrol=111 in EXECUTE; regdst=1 and regwrite=1 in ALUWB; 4 cycles.
- beq with zero=1 in BRANCH: pcen=1, pcsrc=01; repeat with zero=0: pcen=0.
- op=111111: DECODE->FETCH with no regwrite or memwrite; instret unchanged.
- Reset pulsed low during MEMWR: memwrite drops to 0 immediately and state_o=0; instret at 16'hFFFF then one sw wraps it to 0.
- Build without ADDI_J_EN: op=001000 returns to FETCH after DECODE.
